// File: rtl/ofdm_preamble_inserter.sv
// ofdm_preamble_inserter
//   End-of-chain OFDM TX framer. For every payload burst it emits a programmable
//   training preamble held in an internal RAM, then passes the payload through
//   unchanged, then optionally appends a run of zero samples as a guard.
//
// Ports
//   clk, aresetn        clock, asynchronous active-low reset
//   clear               synchronous soft reset: FSM to IDLE, counters cleared;
//                       RAM contents and settings are kept
//   set_stb/addr/data   settings bus (preamble length, RAM pointer/data, guard length)
//   i_t*                AXI-stream payload in; i_tlast marks the last payload sample
//   o_t*                AXI-stream out: preamble + payload + guard; o_tlast ends the burst
//   sof, eof            pulses coincident with the handshake of the first / last
//                       output sample of a burst
//   busy                high whenever the FSM is not IDLE
module ofdm_preamble_inserter #(
  parameter int         WIDTH           = 32,
  parameter int         MAX_LEN_LOG2    = 8,
  parameter logic [7:0] SR_PREAMBLE_LEN = 8'd16,
  parameter logic [7:0] SR_RAM_ADDR     = 8'd17,
  parameter logic [7:0] SR_RAM_DATA     = 8'd18,
  parameter logic [7:0] SR_GAP_LEN      = 8'd19
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int LW    = MAX_LEN_LOG2 + 1;
  localparam int DEPTH = 1 << MAX_LEN_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PREAMBLE,
    S_PAYLOAD,
    S_GAP
  } state_t;

  // Settings registers
  logic [LW-1:0]           preamble_len_q, preamble_len_d;
  logic [15:0]             gap_len_q, gap_len_d;
  logic [MAX_LEN_LOG2-1:0] wr_ptr_q, wr_ptr_d;

  // Burst control
  state_t                  state_q, state_d;
  logic [LW-1:0]           len_sh_q, len_sh_d;
  logic [15:0]             gap_sh_q, gap_sh_d;
  logic [LW-1:0]           rd_addr_q, rd_addr_d;
  logic [LW-1:0]           out_idx_q, out_idx_d;
  logic [15:0]             gap_cnt_q, gap_cnt_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    skid_vld_q, skid_vld_d;
  logic                    first_q, first_d;

  // Preamble data path: presented register plus one-deep skid
  logic [WIDTH-1:0]        head_q, head_d;
  logic [WIDTH-1:0]        skid_q, skid_d;

  // Preamble RAM
  logic [WIDTH-1:0]        ram [DEPTH];
  logic [WIDTH-1:0]        ram_rdata_q;
  logic                    ram_we;
  logic                    ram_re;
  logic [MAX_LEN_LOG2-1:0] ram_raddr;
  logic                    gap_last;

  // Settings decode. RAM data writes are only honoured while IDLE so a burst in
  // flight never sees its preamble change underneath it.
  always_comb begin
    preamble_len_d = preamble_len_q;
    gap_len_d      = gap_len_q;
    wr_ptr_d       = wr_ptr_q;
    ram_we         = 1'b0;
    if (set_stb) begin
      case (set_addr)
        SR_PREAMBLE_LEN: preamble_len_d = set_data[LW-1:0];
        SR_GAP_LEN:      gap_len_d      = set_data[15:0];
        SR_RAM_ADDR:     wr_ptr_d       = set_data[MAX_LEN_LOG2-1:0];
        SR_RAM_DATA: begin
          if (state_q == S_IDLE) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_ptr_q] <= set_data[WIDTH-1:0];
    if (ram_re) ram_rdata_q <= ram[ram_raddr];
  end

  assign gap_last = (gap_cnt_q == gap_sh_q - 16'd1);

  // Main FSM and stream muxing.
  // Read-ahead rule in PREAMBLE: a RAM read is issued only when the skid will be
  // empty next cycle, so the returning word always has a free slot even if the
  // sink stalls. With o_tready high this still issues one read per cycle.
  always_comb begin
    state_d    = state_q;
    len_sh_d   = len_sh_q;
    gap_sh_d   = gap_sh_q;
    rd_addr_d  = rd_addr_q;
    out_idx_d  = out_idx_q;
    gap_cnt_d  = gap_cnt_q;
    skid_vld_d = skid_vld_q;
    first_d    = first_q;
    head_d     = head_q;
    skid_d     = skid_q;
    ram_re     = 1'b0;
    ram_raddr  = rd_addr_q[MAX_LEN_LOG2-1:0];
    o_tdata    = '0;
    o_tvalid   = 1'b0;
    o_tlast    = 1'b0;
    i_tready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The waiting payload sample is not consumed here; it only starts the burst.
        if (i_tvalid) begin
          len_sh_d   = preamble_len_q;
          gap_sh_d   = gap_len_q;
          first_d    = 1'b1;
          out_idx_d  = '0;
          gap_cnt_d  = '0;
          skid_vld_d = 1'b0;
          if (preamble_len_q != '0) begin
            ram_re    = 1'b1;
            ram_raddr = '0;
            rd_addr_d = LW'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end

      S_FETCH: begin
        head_d = ram_rdata_q;
        if (rd_addr_q < len_sh_q) begin
          ram_re    = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
        state_d = S_PREAMBLE;
      end

      S_PREAMBLE: begin
        o_tvalid = 1'b1;
        o_tdata  = head_q;
        if (o_tready) begin
          if (skid_vld_q) begin
            head_d     = skid_q;
            skid_d     = ram_rdata_q;
            skid_vld_d = rd_pend_q;
          end else begin
            head_d     = ram_rdata_q;
            skid_vld_d = 1'b0;
          end
          out_idx_d = out_idx_q + 1'b1;
          if (out_idx_q == len_sh_q - 1'b1) state_d = S_PAYLOAD;
        end else if (rd_pend_q) begin
          skid_d     = ram_rdata_q;
          skid_vld_d = 1'b1;
        end
        if (!skid_vld_d && (rd_addr_q < len_sh_q)) begin
          ram_re    = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end

      S_PAYLOAD: begin
        o_tdata  = i_tdata;
        o_tvalid = i_tvalid;
        i_tready = o_tready;
        o_tlast  = i_tlast && (gap_sh_q == 16'd0);
        if (i_tvalid && o_tready && i_tlast) begin
          gap_cnt_d = '0;
          state_d   = (gap_sh_q == 16'd0) ? S_IDLE : S_GAP;
        end
      end

      S_GAP: begin
        o_tvalid = 1'b1;
        o_tlast  = gap_last;
        if (o_tready) begin
          if (gap_last) state_d = S_IDLE;
          else          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (o_tvalid && o_tready) first_d = 1'b0;

    rd_pend_d = ram_re;

    // Soft reset truncates the burst; the unconsumed payload restarts a new one.
    if (clear) begin
      state_d    = S_IDLE;
      rd_addr_d  = '0;
      out_idx_d  = '0;
      gap_cnt_d  = '0;
      skid_vld_d = 1'b0;
      first_d    = 1'b0;
      rd_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      preamble_len_q <= '0;
      gap_len_q      <= '0;
      wr_ptr_q       <= '0;
      state_q        <= S_IDLE;
      len_sh_q       <= '0;
      gap_sh_q       <= '0;
      rd_addr_q      <= '0;
      out_idx_q      <= '0;
      gap_cnt_q      <= '0;
      rd_pend_q      <= 1'b0;
      skid_vld_q     <= 1'b0;
      first_q        <= 1'b0;
    end else begin
      preamble_len_q <= preamble_len_d;
      gap_len_q      <= gap_len_d;
      wr_ptr_q       <= wr_ptr_d;
      state_q        <= state_d;
      len_sh_q       <= len_sh_d;
      gap_sh_q       <= gap_sh_d;
      rd_addr_q      <= rd_addr_d;
      out_idx_q      <= out_idx_d;
      gap_cnt_q      <= gap_cnt_d;
      rd_pend_q      <= rd_pend_d;
      skid_vld_q     <= skid_vld_d;
      first_q        <= first_d;
    end
  end

  // Data registers carry no reset; their contents are qualified by control state.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

  assign sof  = o_tvalid && o_tready && first_q;
  assign eof  = o_tvalid && o_tready && o_tlast;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ofdm_preamble_inserter.sv
module tb_ofdm_preamble_inserter;

  localparam logic [7:0] A_LEN  = 8'd16;
  localparam logic [7:0] A_ADDR = 8'd17;
  localparam logic [7:0] A_DATA = 8'd18;
  localparam logic [7:0] A_GAP  = 8'd19;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        clear = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        sof;
  logic        eof;
  logic        busy;

  int n_total = 0;
  int n_bad = 0;

  ofdm_preamble_inserter dut (
    .clk(clk), .aresetn(aresetn), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .sof(sof), .eof(eof), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- sink-side monitor ----------------
  logic [34:0] got_q[$];
  logic [34:0] exp_q[$];
  int          cyc = 0;
  int          first_hs = -1;
  int          last_hs = -1;
  int          first_iv = -1;
  bit          after_last = 1'b0;
  int          rdy_in_gap = 0;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_val = '0;
  bit          rnd_ready = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (hold_pend) chk("hold_stable", {32'd0, o_tdata}, {32'd0, hold_val});
    hold_pend = o_tvalid && !o_tready;
    hold_val  = o_tdata;
    if (o_tvalid && o_tready) begin
      got_q.push_back({sof, eof, o_tlast, o_tdata});
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
    if (i_tvalid && first_iv < 0) first_iv = cyc;
    if (after_last && busy && i_tready) rdy_in_gap++;
    if (i_tvalid && i_tready && i_tlast) after_last = 1'b1;
  end

  always begin
    @(posedge clk);
    #1;
    o_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic set_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic send(input logic [31:0] base, input int n, input bit sync);
    logic acc;
    int   w;
    if (sync) begin
      @(posedge clk); #1;
    end
    for (int j = 0; j < n; j++) begin
      i_tdata = base + 32'(j); i_tlast = (j == n - 1); i_tvalid = 1'b1;
      w = 0;
      do begin
        @(negedge clk); acc = i_tready;
        @(posedge clk); #1; w++;
      end while (!acc && w < 3000);
      if (!acc) begin
        chk("send_timeout", {63'd0, acc}, 64'd1);
        break;
      end
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask

  task automatic add_burst(input int len, input logic [31:0] base, input int n, input int gap,
                           input int ov_idx, input logic [31:0] ov_val);
    for (int k = 0; k < len; k++)
      exp_q.push_back({(k == 0), 1'b0, 1'b0, (k == ov_idx) ? ov_val : 32'(k)});
    for (int j = 0; j < n; j++) begin
      logic lst;
      lst = (j == n - 1) && (gap == 0);
      exp_q.push_back({(len == 0 && j == 0), lst, lst, base + 32'(j)});
    end
    for (int g = 0; g < gap; g++)
      exp_q.push_back({1'b0, (g == gap - 1), (g == gap - 1), 32'd0});
  endtask

  task automatic mon_reset();
    got_q.delete(); exp_q.delete();
    first_hs = -1; last_hs = -1; first_iv = -1;
    after_last = 1'b0; rdy_in_gap = 0;
  endtask

  task automatic wait_done(input int n);
    int w;
    w = 0;
    while ((got_q.size() < n || busy) && w < 4000) begin
      @(negedge clk); #1; w++;
    end
    chk("done_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic compare(input string tag);
    int nb;
    nb = 0;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size() && nb < 4; i++) begin
      if (got_q[i] !== exp_q[i]) nb++;
      chk($sformatf("%s[%0d]", tag, i), {29'd0, got_q[i]}, {29'd0, exp_q[i]});
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_o_tvalid", {63'd0, o_tvalid}, 64'd0);
    chk("rst_o_tlast",  {63'd0, o_tlast},  64'd0);
    chk("rst_i_tready", {63'd0, i_tready}, 64'd0);
    chk("rst_sof",      {63'd0, sof},      64'd0);
    chk("rst_eof",      {63'd0, eof},      64'd0);
    chk("rst_busy",     {63'd0, busy},     64'd0);
    @(posedge clk); #1 aresetn = 1'b1;

    // Settings come out of reset as LEN=0, GAP=0: single-sample pure pass-through
    mon_reset();
    send(32'h5A5A_0001, 1, 1'b1);
    add_burst(0, 32'h5A5A_0001, 1, 0, -1, 0);
    wait_done(1);
    compare("s3_single");

    // Load preamble RAM with k at address k
    set_wr(A_ADDR, 32'd0);
    for (int k = 0; k < 160; k++) set_wr(A_DATA, 32'(k));
    set_wr(A_LEN, 32'd160);

    // 160 preamble + 80 payload, full rate
    mon_reset();
    send(32'hA000_0000, 80, 1'b1);
    add_burst(160, 32'hA000_0000, 80, 0, -1, 0);
    wait_done(240);
    compare("s1");
    chk("s1_latency", 64'(first_hs - first_iv), 64'd2);
    chk("s1_no_bubbles", 64'(last_hs - first_hs), 64'd239);

    // Same with a 4-sample zero guard
    set_wr(A_GAP, 32'd4);
    mon_reset();
    send(32'hB000_0000, 80, 1'b1);
    add_burst(160, 32'hB000_0000, 80, 4, -1, 0);
    wait_done(244);
    compare("s2");
    chk("s2_itready_in_gap", 64'(rdy_in_gap), 64'd0);
    set_wr(A_GAP, 32'd0);

    // Random backpressure over three back-to-back bursts
    mon_reset();
    rnd_ready = 1'b1;
    send(32'hC000_0000, 80, 1'b1);
    send(32'hC100_0000, 80, 1'b0);
    send(32'hC200_0000, 80, 1'b0);
    add_burst(160, 32'hC000_0000, 80, 0, -1, 0);
    add_burst(160, 32'hC100_0000, 80, 0, -1, 0);
    add_burst(160, 32'hC200_0000, 80, 0, -1, 0);
    wait_done(720);
    rnd_ready = 1'b0;
    compare("s4");

    // Settings written while busy: LEN applies to next burst, RAM write dropped
    set_wr(A_ADDR, 32'd5);
    mon_reset();
    fork
      send(32'hD000_0000, 8, 1'b1);
      begin
        repeat (20) @(posedge clk);
        chk("s5_busy_at_write", {63'd0, busy}, 64'd1);
        set_wr(A_LEN, 32'd32);
        set_wr(A_DATA, 32'hDEAD_DEAD);
      end
    join
    add_burst(160, 32'hD000_0000, 8, 0, -1, 0);
    wait_done(168);
    compare("s5a");
    mon_reset();
    send(32'hD100_0000, 8, 1'b1);
    add_burst(32, 32'hD100_0000, 8, 0, -1, 0);
    wait_done(40);
    compare("s5b");
    // Pointer must still be 5: this idle write lands at RAM[5]
    set_wr(A_DATA, 32'hBEEF_0005);
    mon_reset();
    send(32'hD200_0000, 8, 1'b1);
    add_burst(32, 32'hD200_0000, 8, 0, 5, 32'hBEEF_0005);
    wait_done(40);
    compare("s5c");
    set_wr(A_ADDR, 32'd5);
    set_wr(A_DATA, 32'd5);
    set_wr(A_LEN, 32'd160);

    // clear during preamble: truncation, then full restart from RAM[0]
    mon_reset();
    fork
      send(32'hE000_0000, 8, 1'b1);
      begin
        w = 0;
        while (got_q.size() < 50 && w < 2000) begin
          @(negedge clk); #1; w++;
        end
        chk("s6_reach50", 64'(got_q.size()), 64'd50);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk); #1;
        chk("s6_tvalid_after_clear", {63'd0, o_tvalid}, 64'd0);
        chk("s6_busy_after_clear", {63'd0, busy}, 64'd0);
      end
    join
    for (int k = 0; k <= 50; k++) exp_q.push_back({(k == 0), 1'b0, 1'b0, 32'(k)});
    add_burst(160, 32'hE000_0000, 8, 0, -1, 0);
    wait_done(51 + 168);
    compare("s6");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
